// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline control path.
// Forward selects, MUL/DIV sequencer states and the register-0 helper.
package pipeline_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // A write to register 0 is discarded, so it can never be a producer.
  function automatic logic reg_hit(
    input logic [4:0] dst,
    input logic [4:0] src
  );
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// IDLE/BUSY/DONE sequencer for the multi-cycle MUL/DIV unit.
// BUSY lasts exactly the loaded count; DONE is a one-cycle HI/LO write.
module muldiv_sequencer
  import pipeline_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o,
  output logic active_o,
  output logic err_o
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  muldiv_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_q   <= is_div_i ? DIV_LD : MUL_LD;
            state_q <= BUSY;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          if (start_i) err_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          if (start_i) err_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign active_o = (state_q != IDLE);
  assign err_o    = err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for the 5-stage pipeline: forwarding, stalls, flushes.
// MUL/DIV sequencing lives in muldiv_sequencer.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  input  logic       jump_d,
  input  logic       pc_src_d,
  input  logic       muldiv_req_d,
  input  logic       hilo_read_d,
  input  logic       muldiv_start_e,
  input  logic       muldiv_is_div_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       forward_a_d,
  output logic       forward_b_d,
  output logic       muldiv_busy,
  output logic       muldiv_done,
  output logic       protocol_err
);

  logic md_active;
  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic stall;

  muldiv_sequencer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (muldiv_start_e),
    .is_div_i (muldiv_is_div_e),
    .busy_o   (muldiv_busy),
    .done_o   (muldiv_done),
    .active_o (md_active),
    .err_o    (protocol_err)
  );

  // M is the younger producer, so it wins over W.
  always_comb begin
    forward_a_e = FWD_RF;
    if (reg_write_m && reg_hit(write_reg_m, rs_e))
      forward_a_e = FWD_M;
    else if (reg_write_w && reg_hit(write_reg_w, rs_e))
      forward_a_e = FWD_W;
  end

  always_comb begin
    forward_b_e = FWD_RF;
    if (reg_write_m && reg_hit(write_reg_m, rt_e))
      forward_b_e = FWD_M;
    else if (reg_write_w && reg_hit(write_reg_w, rt_e))
      forward_b_e = FWD_W;
  end

  assign forward_a_d = reg_write_m && reg_hit(write_reg_m, rs_d);
  assign forward_b_d = reg_write_m && reg_hit(write_reg_m, rt_d);

  assign lw_stall = mem_to_reg_e &&
                    (reg_hit(rt_e, rs_d) || reg_hit(rt_e, rt_d));

  assign br_stall = branch_d && (
      (reg_write_e &&
       (reg_hit(write_reg_e, rs_d) || reg_hit(write_reg_e, rt_d))) ||
      (mem_to_reg_m &&
       (reg_hit(write_reg_m, rs_d) || reg_hit(write_reg_m, rt_d))));

  // DONE still counts: HI/LO is only written at the end of that cycle.
  assign md_stall = md_active && (hilo_read_d || muldiv_req_d);

  assign stall = lw_stall | br_stall | md_stall;

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;
  assign flush_d = (pc_src_d | jump_d) && !stall;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl with an expected-vector queue.
// Vector: {stall_f,stall_d,flush_d,flush_e,fa_e,fb_e,fa_d,fb_d,busy,done,err}.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, jump_d, pc_src_d;
  logic       muldiv_req_d, hilo_read_d;
  logic       muldiv_start_e, muldiv_is_div_e;
  logic       stall_f, stall_d, flush_d, flush_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic       forward_a_d, forward_b_d;
  logic       muldiv_busy, muldiv_done, protocol_err;

  int checks = 0;
  int failures = 0;
  logic [12:0] exp_q[$];
  logic [12:0] e;
  logic [12:0] obs;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (32),
    .CNT_W      (6)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs_d            (rs_d),
    .rt_d            (rt_d),
    .rs_e            (rs_e),
    .rt_e            (rt_e),
    .write_reg_e     (write_reg_e),
    .write_reg_m     (write_reg_m),
    .write_reg_w     (write_reg_w),
    .reg_write_e     (reg_write_e),
    .reg_write_m     (reg_write_m),
    .reg_write_w     (reg_write_w),
    .mem_to_reg_e    (mem_to_reg_e),
    .mem_to_reg_m    (mem_to_reg_m),
    .branch_d        (branch_d),
    .jump_d          (jump_d),
    .pc_src_d        (pc_src_d),
    .muldiv_req_d    (muldiv_req_d),
    .hilo_read_d     (hilo_read_d),
    .muldiv_start_e  (muldiv_start_e),
    .muldiv_is_div_e (muldiv_is_div_e),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .flush_e         (flush_e),
    .forward_a_e     (forward_a_e),
    .forward_b_e     (forward_b_e),
    .forward_a_d     (forward_a_d),
    .forward_b_d     (forward_b_d),
    .muldiv_busy     (muldiv_busy),
    .muldiv_done     (muldiv_done),
    .protocol_err    (protocol_err)
  );

  assign obs = {stall_f, stall_d, flush_d, flush_e,
                forward_a_e, forward_b_e, forward_a_d, forward_b_d,
                muldiv_busy, muldiv_done, protocol_err};

  function automatic logic [12:0] pk(
    input logic st, input logic fd,
    input logic [1:0] fae, input logic [1:0] fbe,
    input logic fad, input logic fbd,
    input logic bz, input logic dn, input logic er
  );
    return {st, st, fd, st, fae, fbe, fad, fbd, bz, dn, er};
  endfunction

  task automatic clr_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0;
    branch_d = 0; jump_d = 0; pc_src_d = 0;
    muldiv_req_d = 0; hilo_read_d = 0;
    muldiv_start_e = 0; muldiv_is_div_e = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst_n = 1'b0;
    #3;
    exp_q.push_back(pk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", obs, e);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    tick();
    clr_inputs();
    rs_e = 5; reg_write_m = 1; write_reg_m = 5;
    reg_write_w = 1; write_reg_w = 5;
    exp_q.push_back(pk(0, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL fwd_m_over_w got=%h exp=%h", obs, e);
    end
    reg_write_m = 0;
    exp_q.push_back(pk(0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL fwd_w got=%h exp=%h", obs, e);
    end
    rs_e = 0;
    exp_q.push_back(pk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL fwd_rs0 got=%h exp=%h", obs, e);
    end
    rs_e = 6; rt_e = 5; reg_write_m = 1; write_reg_m = 5;
    write_reg_w = 6; rs_d = 5; rt_d = 9;
    exp_q.push_back(pk(0, 0, 2'b01, 2'b10, 1, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL fwd_mixed got=%h exp=%h", obs, e);
    end
    clr_inputs();
    reg_write_m = 1; reg_write_w = 1;
    exp_q.push_back(pk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL fwd_reg0 got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_load_use();
    tick();
    clr_inputs();
    mem_to_reg_e = 1; rt_e = 8; rs_d = 8;
    exp_q.push_back(pk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL lw_stall got=%h exp=%h", obs, e);
    end
    rs_d = 0; rt_d = 8; jump_d = 1;
    exp_q.push_back(pk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL lw_rt_over_jump got=%h exp=%h", obs, e);
    end
    rt_e = 0; rt_d = 0; rs_d = 0; jump_d = 0;
    exp_q.push_back(pk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL lw_reg0 got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_branch();
    tick();
    clr_inputs();
    branch_d = 1; pc_src_d = 1; reg_write_e = 1;
    write_reg_e = 3; rs_d = 3;
    exp_q.push_back(pk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL br_stall got=%h exp=%h", obs, e);
    end
    tick();
    reg_write_e = 0;
    exp_q.push_back(pk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL br_flush got=%h exp=%h", obs, e);
    end
    pc_src_d = 0; mem_to_reg_m = 1; write_reg_m = 4; rt_d = 4;
    exp_q.push_back(pk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL br_load_m got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_multiply();
    tick();
    clr_inputs();
    muldiv_start_e = 1; hilo_read_d = 1;
    exp_q.push_back(pk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL mul_c0 got=%h exp=%h", obs, e);
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      muldiv_start_e = 0;
      exp_q.push_back(pk(c <= 5, 0, 2'b00, 2'b00, 0, 0,
                         c <= 4, c == 5, 0));
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mul_c%0d got=%h exp=%h", c, obs, e);
      end
    end
  endtask

  task automatic test_start_with_lw();
    tick();
    clr_inputs();
    muldiv_start_e = 1; mem_to_reg_e = 1; rt_e = 2; rs_d = 2;
    exp_q.push_back(pk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL lw_start_c0 got=%h exp=%h", obs, e);
    end
    tick();
    clr_inputs();
    muldiv_req_d = 1;
    exp_q.push_back(pk(1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL lw_start_busy got=%h exp=%h", obs, e);
    end
    repeat (5) tick();
    muldiv_req_d = 0;
  endtask

  task automatic test_protocol_err();
    tick();
    clr_inputs();
    muldiv_start_e = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      muldiv_start_e = (c == 2);
      muldiv_is_div_e = (c == 2);
      exp_q.push_back(pk(0, 0, 2'b00, 2'b00, 0, 0,
                         c <= 4, c == 5, c >= 3));
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL perr_c%0d got=%h exp=%h", c, obs, e);
      end
    end
  endtask

  task automatic test_div_reset();
    tick();
    clr_inputs();
    muldiv_start_e = 1; muldiv_is_div_e = 1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      muldiv_start_e = 0;
    end
    exp_q.push_back(pk(0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL div_busy_c10 got=%h exp=%h", obs, e);
    end
    rst_n = 1'b0;
    exp_q.push_back(pk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL div_rst_now got=%h exp=%h", obs, e);
    end
    tick();
    rst_n = 1'b1;
    hilo_read_d = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      exp_q.push_back(pk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL div_after_rst_c%0d got=%h exp=%h", c, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_multiply();
    test_start_with_lw();
    test_protocol_err();
    test_div_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
